// File: rtl/pic_cw_sequencer.sv
// Clocked ICW/OCW command-word decoder for the PIC, with an explicit ICW state machine.
// Optional macro PIC_INPUT_SYNC_EN adds a 2-flop synchroniser on all bus inputs.
module pic_cw_sequencer #(
  parameter int N_IR  = 8,
  parameter int LVL_W = $clog2(N_IR)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs_neg,
  input  logic             wr_neg,
  input  logic             a0,
  input  logic             sp_neg,
  input  logic [7:0]       data_bus_buffer,
  output logic             single_mode_flag,
  output logic             level_trigger_flag,
  output logic [4:0]       vector_base,
  output logic [7:0]       slaves_connected_flag,
  output logic [2:0]       my_slave_id,
  output logic             aeoi_flag,
  output logic [N_IR-1:0]  imr,
  output logic [LVL_W-1:0] ir_level,
  output logic [2:0]       ocw2_cmd,
  output logic             ocw2_valid,
  output logic             automatic_rotation_mode_flag,
  output logic [1:0]       read_type_flag,
  output logic             poll_request,
  output logic             special_mask_mode_flag,
  output logic             ready_to_accept_interrupts_flag,
  output logic             cw_error
);

  typedef enum logic [2:0] {ICW1_WAIT, ICW2, ICW3, ICW4, READY} state_t;

  state_t      state, state_nxt;
  logic        wr_prev;
  logic        commit;
  logic        cmd_a0;
  logic [7:0]  cmd_data;

`ifdef PIC_INPUT_SYNC_EN
  logic [1:0] cs_sync, wr_sync, a0_sync;
  logic [7:0] d_sync1, d_sync2;

  // Commit is decoded straight from the synchronised strobe so the total latency stays at 3 edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync <= 2'b11;
      wr_sync <= 2'b11;
      a0_sync <= 2'b00;
      d_sync1 <= 8'h00;
      d_sync2 <= 8'h00;
      wr_prev <= 1'b1;
    end else begin
      cs_sync <= {cs_sync[0], cs_neg};
      wr_sync <= {wr_sync[0], wr_neg};
      a0_sync <= {a0_sync[0], a0};
      d_sync1 <= data_bus_buffer;
      d_sync2 <= d_sync1;
      wr_prev <= wr_sync[1];
    end
  end

  assign commit   = wr_sync[1] & ~wr_prev & ~cs_sync[1];
  assign cmd_a0   = a0_sync[1];
  assign cmd_data = d_sync2;
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_prev  <= 1'b1;
      commit   <= 1'b0;
      cmd_a0   <= 1'b0;
      cmd_data <= 8'h00;
    end else begin
      wr_prev  <= wr_neg;
      commit   <= wr_neg & ~wr_prev & ~cs_neg;
      cmd_a0   <= a0;
      cmd_data <= data_bus_buffer;
    end
  end
`endif

  logic             ic4, ic4_nxt;
  logic             single_nxt, ltim_nxt, aeoi_nxt, arm_nxt, smm_nxt;
  logic             ocw2_valid_nxt, poll_nxt, err_nxt;
  logic [4:0]       vb_nxt;
  logic [7:0]       slaves_nxt;
  logic [2:0]       id_nxt, cmd_nxt;
  logic [N_IR-1:0]  imr_nxt;
  logic [LVL_W-1:0] lvl_nxt;
  logic [1:0]       rt_nxt;

  always_comb begin
    state_nxt      = state;
    ic4_nxt        = ic4;
    single_nxt     = single_mode_flag;
    ltim_nxt       = level_trigger_flag;
    vb_nxt         = vector_base;
    slaves_nxt     = slaves_connected_flag;
    id_nxt         = my_slave_id;
    aeoi_nxt       = aeoi_flag;
    imr_nxt        = imr;
    lvl_nxt        = ir_level;
    cmd_nxt        = ocw2_cmd;
    arm_nxt        = automatic_rotation_mode_flag;
    rt_nxt         = read_type_flag;
    smm_nxt        = special_mask_mode_flag;
    ocw2_valid_nxt = 1'b0;
    poll_nxt       = 1'b0;
    err_nxt        = 1'b0;
    if (commit) begin
      if (!cmd_a0 && cmd_data[4]) begin
        // ICW1 restarts initialisation from any state, abandoning a partial sequence silently
        imr_nxt    = '0;
        lvl_nxt    = '0;
        arm_nxt    = 1'b0;
        smm_nxt    = 1'b0;
        rt_nxt     = 2'b10;
        aeoi_nxt   = 1'b0;
        single_nxt = cmd_data[1];
        ltim_nxt   = cmd_data[3];
        ic4_nxt    = cmd_data[0];
        state_nxt  = ICW2;
      end else begin
        case (state)
          ICW1_WAIT: if (cmd_a0) err_nxt = 1'b1;
          ICW2: begin
            if (cmd_a0) begin
              vb_nxt = cmd_data[7:3];
              if (!single_mode_flag) state_nxt = ICW3;
              else if (ic4)          state_nxt = ICW4;
              else                   state_nxt = READY;
            end else err_nxt = 1'b1;
          end
          ICW3: begin
            if (cmd_a0) begin
              if (sp_neg) slaves_nxt = cmd_data;
              else        id_nxt     = cmd_data[2:0];
              state_nxt = ic4 ? ICW4 : READY;
            end else err_nxt = 1'b1;
          end
          ICW4: begin
            if (cmd_a0) begin
              aeoi_nxt  = cmd_data[1];
              state_nxt = READY;
            end else err_nxt = 1'b1;
          end
          READY: begin
            if (cmd_a0) begin
              imr_nxt = cmd_data[N_IR-1:0];
            end else if (!cmd_data[3]) begin
              lvl_nxt        = cmd_data[LVL_W-1:0];
              cmd_nxt        = cmd_data[7:5];
              ocw2_valid_nxt = 1'b1;
              if (cmd_data[7:5] == 3'b100)      arm_nxt = 1'b1;
              else if (cmd_data[7:5] == 3'b000) arm_nxt = 1'b0;
            end else if (cmd_data[7]) begin
              err_nxt = 1'b1;
            end else begin
              if (cmd_data[1]) rt_nxt  = {1'b1, cmd_data[0]};
              if (cmd_data[2]) poll_nxt = 1'b1;
              if (cmd_data[6]) smm_nxt = cmd_data[5];
            end
          end
          default: state_nxt = ICW1_WAIT;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                        <= ICW1_WAIT;
      ic4                          <= 1'b0;
      single_mode_flag             <= 1'b0;
      level_trigger_flag           <= 1'b0;
      vector_base                  <= 5'd0;
      slaves_connected_flag        <= 8'h00;
      my_slave_id                  <= 3'd0;
      aeoi_flag                    <= 1'b0;
      imr                          <= '0;
      ir_level                     <= '0;
      ocw2_cmd                     <= 3'd0;
      ocw2_valid                   <= 1'b0;
      automatic_rotation_mode_flag <= 1'b0;
      read_type_flag               <= 2'b10;
      poll_request                 <= 1'b0;
      special_mask_mode_flag       <= 1'b0;
      cw_error                     <= 1'b0;
    end else begin
      state                        <= state_nxt;
      ic4                          <= ic4_nxt;
      single_mode_flag             <= single_nxt;
      level_trigger_flag           <= ltim_nxt;
      vector_base                  <= vb_nxt;
      slaves_connected_flag        <= slaves_nxt;
      my_slave_id                  <= id_nxt;
      aeoi_flag                    <= aeoi_nxt;
      imr                          <= imr_nxt;
      ir_level                     <= lvl_nxt;
      ocw2_cmd                     <= cmd_nxt;
      ocw2_valid                   <= ocw2_valid_nxt;
      automatic_rotation_mode_flag <= arm_nxt;
      read_type_flag               <= rt_nxt;
      poll_request                 <= poll_nxt;
      special_mask_mode_flag       <= smm_nxt;
      cw_error                     <= err_nxt;
    end
  end

  assign ready_to_accept_interrupts_flag = (state == READY);

endmodule
